// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, NZCV flags and condition check.
// Define PERF_CNT_EN to add the InstrCount retired/squashed instruction counter output.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t     state, next_state;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] flags;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_ex, cond_ex_r;
  logic       reg_w, mem_w, next_pc, branch, alu_op, pcs;
  logic [1:0] flag_w;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      cond_ex_r <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        cond_ex_r <= cond_ex;
      // Flags move only at the end of execute, so the same instruction's writeback still uses cond_ex_r.
      if ((state == S_EXECR || state == S_EXECI) && cond_ex_r) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    next_pc    = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_pc    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   next_state = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Unrecognised commands fall back to ADD and therefore still update C/V.
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ~ALUControl[1];
    end
  end

  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign pcs      = (rd == 4'd15) & ((op == 2'b00) | ((op == 2'b01) & funct[0]));
  assign MemWrite = mem_w & cond_ex_r;
  assign RegWrite = reg_w & cond_ex_r;
  assign PCWrite  = next_pc | (branch & cond_ex_r) | (reg_w & cond_ex_r & pcs);

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      InstrCount <= 32'd0;
    else if (state != S_FETCH && next_state == S_FETCH)
      InstrCount <= InstrCount + 32'd1;
  end
`endif

endmodule

// File: doc/mc_controller.md
# mc_controller

Control unit for the multicycle ARM-subset processor: sequences the shared datapath (single memory port, shared ALU, IR/ALUOut/Data registers) through fetch, decode, execute, memory and writeback cycles. Holds the main FSM, the ALU decoder, the NZCV flags register and condition-check logic. Instantiated inside `top` next to the datapath; drives every enable and mux select.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  IR bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  ALU result flags {N,Z,C,V}
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  1  0=RD1 register, 1=PC
- ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [1]=(Op==01), [0]=(Op==10)
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

## Operation
- Moore FSM, 10 states. Unlisted outputs 0/00; RegW, MemW, NextPC, Branch, ALUOp are internal.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1 -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; latch CondExR. Op=01 -> MEMADR; Op=00,Funct[5]=0 -> EXECUTER; Op=00,Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (no side effects).
- MEMADR: ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMREAD else MEMWRITE.
- MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemW=1 -> FETCH.
- EXECUTER: ALUSrcB=00, ALUOp=1 -> ALUWB. EXECUTEI: ALUSrcB=01, ALUOp=1 -> ALUWB.
- ALUWB: RegW=1 -> FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
- ALU decoder: ALUOp=0 -> ADD. ALUOp=1, cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, other -> ADD. S=Funct[0]; FlagW[1](NZ)=ALUOp&S; FlagW[0](CV)=ALUOp&S&(ADD|SUB).
- CondEx combinational from Instr[31:28] and flags register: EQ..LE standard ARM; 1110 AL=1; 1111=0.
- CondExR: register, loaded with CondEx at end of DECODE only; gates all later-state writes.
- PCS = (Rd==15) & RegW-type instruction (Op=00, or Op=01 with Funct[0]=1).
- MemWrite=MemW&CondExR; RegWrite=RegW&CondExR; PCWrite=NextPC | (Branch&CondExR) | (RegW&CondExR&PCS).
- Flags: NZ loaded from ALUFlags[3:2] at end of EXECUTER/EXECUTEI when FlagW[1]&CondExR; CV from ALUFlags[1:0] when FlagW[0]&CondExR.

## Timing
- Reset (sampled on rising edge): state=FETCH, flags=0000, CondExR=0. Outputs during and after reset are FETCH values: PCWrite=1, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, rest 0.
- Reset mid-instruction: aborts at next edge; no write occurs in that cycle's gated outputs beyond the FETCH values.
- Cycles per instruction: B 3, data-processing 4, STR 4, LDR 5, Op=11 2.
- Flag update during EXECUTE does not affect the same instruction's ALUWB (CondExR already latched).
- ImmSrc, RegSrc, ALUControl combinational from Instr, valid in any state.

## Configuration
- PERF_CNT_EN defined: adds output InstrCount [31:0]; reset 0; increments by 1 on every transition into FETCH from a non-FETCH state (retired or squashed instruction); wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset held 2 cycles -> PCWrite=1, IRWrite=1, MemWrite=0, RegWrite=0, state FETCH; flags=0.
- ADD R-type, Cond=1110 (Instr=20'hE0800) -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in cycle 4; ALUControl=00.
- LDR (Op=01, Funct[0]=1, Cond=AL) -> 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01, RegWrite=1 in MEMWB.
- STR Cond=AL -> MemWrite=1 exactly one cycle (MEMWRITE); same STR with Cond=EQ, Z=0 -> MemWrite never 1.
- SUBS setting Z=1, then BEQ -> flags Z=1 after EXECUTER; BEQ PCWrite=1 in FETCH and BRANCH; BNE -> PCWrite only in FETCH.
- Reset asserted in MEMADR of LDR -> next state FETCH, RegWrite never 1; with PERF_CNT_EN, InstrCount=0.
